// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM states, stall encodings
// and the per-stage stall bit positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MC_BUSY,
        ST_FLUSH
    } pipe_state_t;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned STALL_PC_B  = 0;
    localparam int unsigned STALL_IF_B  = 1;
    localparam int unsigned STALL_ID_B  = 2;
    localparam int unsigned STALL_EX_B  = 3;
    localparam int unsigned STALL_MEM_B = 4;
    localparam int unsigned STALL_WB_B  = 5;

    // Holding a stage also holds everything upstream of it.
    function automatic logic [STALL_W-1:0] stall_upto(input int unsigned last_b);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STALL_W; i++) begin
            if (i <= last_b) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_ID   = stall_upto(STALL_ID_B);
    localparam logic [STALL_W-1:0] STALL_EX   = stall_upto(STALL_EX_B);

endpackage

// File: rtl/pipe_ctrl_perf_sat_cnt.sv
// 32-bit saturating event counter with synchronous clear; clear beats increment.
module perf_sat_cnt (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall vector, multi-cycle EX tracking,
// registered flush/redirect pulse and a stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 6,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               mc_start,
    input  logic [CNT_W-1:0]   mc_cycles,
    input  logic               flush_req,
    input  logic [31:0]        flush_pc,
    input  logic               perf_clr,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               mc_busy,
    output logic [31:0]        stall_cycles
);

    localparam logic [1:0] FCNT_LOAD = 2'(FLUSH_CYCLES - 1);

    pipe_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_fcnt, w_fcnt_nxt;
    logic [31:0]        r_new_pc, w_new_pc_nxt;
    logic [STALL_W-1:0] w_stall;
    logic [STALL_W-1:0] w_stall_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_fcnt   <= '0;
            r_new_pc <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_new_pc <= w_new_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_fcnt_nxt   = r_fcnt;
        w_new_pc_nxt = r_new_pc;
        w_stall      = STALL_NONE;

        case (r_state)
            ST_IDLE: begin
                if (flush_req) begin
                    w_state_nxt  = ST_FLUSH;
                    w_new_pc_nxt = flush_pc;
                    w_fcnt_nxt   = FCNT_LOAD;
                end else if (mc_start) begin
                    // A zero-length op issues no stall and also masks the ID request.
                    if (mc_cycles != '0) begin
                        w_stall = STALL_EX;
                        if (mc_cycles != CNT_W'(1)) begin
                            w_cnt_nxt   = mc_cycles - CNT_W'(1);
                            w_state_nxt = ST_MC_BUSY;
                        end
                    end
                end else if (stallreq_id) begin
                    w_stall = STALL_ID;
                end
            end

            ST_MC_BUSY: begin
                if (flush_req) begin
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_FLUSH;
                    w_new_pc_nxt = flush_pc;
                    w_fcnt_nxt   = FCNT_LOAD;
                end else begin
                    w_stall = STALL_EX;
                    if (r_cnt == CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end

            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_fcnt_nxt = r_fcnt - 2'd1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stall is combinational on the inputs, so it must be forced low while reset is held.
    assign w_stall_out = rst ? w_stall : STALL_NONE;

    assign stall   = w_stall_out;
    assign flush   = (r_state == ST_FLUSH);
    assign mc_busy = (r_state == ST_MC_BUSY);
    assign new_pc  = r_new_pc;

    perf_sat_cnt u_perf (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (perf_clr),
        .i_inc   (w_stall_out != STALL_NONE),
        .o_cnt   (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic [31:0] stall_cycles;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pipe_ctrl #(
        .CNT_W        (6),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .perf_clr     (perf_clr),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .stall_cycles (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "stall",        32'(stall),   32'(e.stall));
            chk(e.name, "flush",        32'(flush),   32'(e.flush));
            chk(e.name, "new_pc",       new_pc,       e.pc);
            chk(e.name, "mc_busy",      32'(mc_busy), 32'(e.busy));
            chk(e.name, "stall_cycles", stall_cycles, e.sc);
        end
    end

    // One cycle: drive inputs just after posedge, queue the outputs expected at the following negedge.
    task automatic step(input string nm, input logic r, input logic sid, input logic mcs,
                        input logic [5:0] mcc, input logic frq, input logic [31:0] fpc, input logic clr,
                        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                        input logic e_busy, input logic [31:0] e_sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        stallreq_id = sid;
        mc_start    = mcs;
        mc_cycles   = mcc;
        flush_req   = frq;
        flush_pc    = fpc;
        perf_clr    = clr;
        e.name  = nm;
        e.stall = e_stall;
        e.flush = e_flush;
        e.pc    = e_pc;
        e.busy  = e_busy;
        e.sc    = e_sc;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b0; stallreq_id = 1'b0; mc_start = 1'b0; mc_cycles = '0;
        flush_req = 1'b0; flush_pc = '0; perf_clr = 1'b0;

        //    name         rst sid mcs mcc frq fpc           clr  stall    fl pc            busy sc
        step("in_reset",   0,  1,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("rst_rel",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("idle",       1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        // ID load-use stall for 3 cycles
        step("id0",        1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h0,        0,   32'd0);
        step("id1",        1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h0,        0,   32'd1);
        step("id2",        1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h0,        0,   32'd2);
        step("id_done",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd3);
        // 5-cycle multi-cycle op, stallreq_id ignored while busy
        step("mc5_s",      1,  0,  1,  5,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        0,   32'd3);
        step("mc5_b1",     1,  1,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        1,   32'd4);
        step("mc5_b2",     1,  1,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        1,   32'd5);
        step("mc5_b3",     1,  1,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        1,   32'd6);
        step("mc5_b4",     1,  1,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        1,   32'd7);
        step("mc5_done",   1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd8);
        // single-cycle and zero-cycle ops
        step("mc1",        1,  0,  1,  1,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        0,   32'd8);
        step("mc1_done",   1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd9);
        step("mc0",        1,  0,  1,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd9);
        step("mc0_done",   1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd9);
        // flush while MC_BUSY with cnt=3
        step("mcf_s",      1,  0,  1,  5,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        0,   32'd9);
        step("mcf_b1",     1,  0,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h0,        1,   32'd10);
        step("mcf_req",    1,  0,  0,  0,  1,  32'h180,      0,   6'h00,   0, 32'h0,        1,   32'd11);
        step("mcf_fl1",    1,  1,  1,  3,  1,  32'h999,      0,   6'h00,   1, 32'h180,      0,   32'd11);
        step("mcf_fl2",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   1, 32'h180,      0,   32'd11);
        step("mcf_idle",   1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h180,      0,   32'd11);
        step("mcf_idle2",  1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h180,      0,   32'd12);
        // flush_req and mc_start together: flush wins
        step("fm_req",     1,  0,  1,  4,  1,  32'h2A0,      0,   6'h00,   0, 32'h180,      0,   32'd12);
        step("fm_fl1",     1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   1, 32'h2A0,      0,   32'd12);
        step("fm_fl2",     1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   1, 32'h2A0,      0,   32'd12);
        step("fm_idle",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h2A0,      0,   32'd12);

        // preload the counter just below saturation
        @(negedge clk);
        #1;
        force dut.u_perf.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_perf.r_cnt;

        step("sat0",       1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h2A0,      0,   32'hFFFF_FFFE);
        step("sat1",       1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h2A0,      0,   32'hFFFF_FFFF);
        step("sat2",       1,  1,  0,  0,  0,  32'h0,        0,   6'h07,   0, 32'h2A0,      0,   32'hFFFF_FFFF);
        step("sat_hold",   1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h2A0,      0,   32'hFFFF_FFFF);
        step("clr_stall",  1,  1,  0,  0,  0,  32'h0,        1,   6'h07,   0, 32'h2A0,      0,   32'hFFFF_FFFF);
        step("clr_done",   1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h2A0,      0,   32'd0);
        // async reset in MC_BUSY
        step("rmc_s",      1,  0,  1,  5,  0,  32'h0,        0,   6'h0F,   0, 32'h2A0,      0,   32'd0);
        step("rmc_b1",     1,  0,  0,  0,  0,  32'h0,        0,   6'h0F,   0, 32'h2A0,      1,   32'd1);
        step("rmc_rst",    0,  1,  1,  5,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("rmc_rel",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        // async reset in FLUSH
        step("rfl_req",    1,  0,  0,  0,  1,  32'h44,       0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("rfl_fl1",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   1, 32'h44,       0,   32'd0);
        step("rfl_rst",    0,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("rfl_rel",    1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);
        step("final",      1,  0,  0,  0,  0,  32'h0,        0,   6'h00,   0, 32'h0,        0,   32'd0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It tracks multi-cycle EX operations (mult-accumulate, divide) with a down-counter. It also issues a registered flush pulse with a redirect PC on exception or redirect requests, and keeps a saturating stall-cycle performance counter.

Parameters:
CNT_W, 6, width of the multi-cycle length field and internal counter
FLUSH_CYCLES, 1, number of consecutive cycles the flush output is held (1..3)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
stallreq_id  in  1  ID load-use hazard, level, same-cycle
mc_start  in  1  EX begins a multi-cycle op, one-cycle pulse
mc_cycles  in  CNT_W  total EX stall cycles for the op; 0 = no stall
flush_req  in  1  exception/redirect request, one-cycle pulse
flush_pc  in  32  redirect target, valid with flush_req
perf_clr  in  1  synchronous clear of stall_cycles
stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = hold
flush  out  1  clear all pipeline registers (registered)
new_pc  out  32  redirect PC, valid while flush=1 (registered)
mc_busy  out  1  multi-cycle stall in progress
stall_cycles  out  32  count of cycles with stall != 0, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, flush=0, new_pc=0, stall_cycles=0, mc_busy=0. stall=0 while in reset.
- FSM states: IDLE, MC_BUSY, FLUSH. Priority is flush_req > multi-cycle > stallreq_id.
- stall encoding: ID stall = 6'b000111; EX stall = 6'b001111; none = 6'b000000. stall is combinational from state plus current inputs, with no added latency.
- IDLE:
  - flush_req=1: go to FLUSH; latch new_pc<=flush_pc; fcnt<=FLUSH_CYCLES-1; stall=0 this cycle.
  - Else mc_start=1 and mc_cycles>=1: stall=EX this cycle. If mc_cycles==1, stay IDLE (single stall cycle). Otherwise cnt<=mc_cycles-1 and go to MC_BUSY.
  - Else mc_start=1 and mc_cycles==0: no stall.
  - Else stallreq_id=1: stall=ID; stay IDLE.
- MC_BUSY:
  - stall=EX and mc_busy=1.
  - cnt decrements each cycle. On the cycle with cnt==1, return to IDLE next cycle.
  - Total EX-stall cycles equal mc_cycles exactly, counting the start cycle.
  - stallreq_id and mc_start are ignored; ID is already held.
  - flush_req: abort, cnt<=0, go to FLUSH, latch flush_pc; stall=0 that cycle.
- FLUSH:
  - flush=1 and stall=0 for FLUSH_CYCLES cycles, beginning the cycle after flush_req. new_pc is held stable throughout.
  - mc_start, stallreq_id and further flush_req are ignored.
  - After the last flush cycle, return to IDLE with flush=0. new_pc keeps its value.
- stall_cycles: increments on every posedge where stall!=0.
  - Saturates at 32'hFFFF_FFFF.
  - perf_clr has priority and loads 0; a simultaneous stall cycle is not counted.
- An async reset mid-MC_BUSY or mid-FLUSH returns immediately to IDLE with all outputs at reset values.
- All counter arithmetic is unsigned CNT_W bits. mc_cycles-1 is computed only when mc_cycles>=1, so it never wraps.

Decomposition:
- Shared defines: stall encodings STALL_NONE/STALL_ID/STALL_EX, state encodings, and the stall bit indices, all in defines.v next to the existing stage macros.
- One natural sub-module: perf_sat_cnt (32-bit saturating counter with sync clear), reusable for other performance counters.
- The FSM and down-counter stay in pipe_ctrl.

Test Plan:
- Reset release, idle inputs -> stall=0, flush=0, new_pc=0, stall_cycles=0. Assert rst=0 mid-operation -> all outputs return to 0 immediately.
- stallreq_id=1 for 3 cycles -> stall=6'b000111 on exactly those 3 cycles; stall_cycles=3.
- mc_start with mc_cycles=5 -> stall=6'b001111 for 5 consecutive cycles starting that cycle, mc_busy=1 for the last 4; stallreq_id=1 during that window has no extra effect. mc_cycles=1 -> one stall cycle, mc_busy never 1. mc_cycles=0 -> no stall.
- flush_req with flush_pc=32'h0000_0180 in MC_BUSY (cnt=3) -> stall=0 that cycle; the next cycle flush=1, new_pc=32'h180, mc_busy=0. With FLUSH_CYCLES=2, flush is high for 2 cycles, then the FSM is back in IDLE.
- flush_req and mc_start in the same IDLE cycle -> flush wins; no EX stall occurs.
- Force stall_cycles to 32'hFFFF_FFFE, then 3 stall cycles -> value is 32'hFFFF_FFFF. perf_clr together with a stall cycle -> value is 0.
